// File: rtl/upscaler_pkg.sv
// Shared video-upscaler definitions: input lock state encoding and default NTSC-class timing limits.
// Timing constants are in 50 MHz sys_clk cycles; line/field counts are in lines.
package upscaler_pkg;

    typedef enum logic [1:0] {
        NO_SIGNAL = 2'd0,
        ACQUIRE   = 2'd1,
        LOCKED    = 2'd2,
        HOLD      = 2'd3
    } lock_state_t;

    localparam int DEF_LINE_MIN    = 3000;
    localparam int DEF_LINE_MAX    = 3350;
    localparam int DEF_LINES_MIN   = 240;
    localparam int DEF_LINES_MAX   = 320;
    localparam int DEF_LOCK_FIELDS = 4;
    localparam int DEF_LOSS_FIELDS = 3;
    localparam int DEF_TIMEOUT     = 2000000;

endpackage

// File: rtl/toggle_sync.sv
// Brings a toggle-encoded event across into sys_clk: 2-flop synchronizer plus edge detect.
// Latency: pulse high in the 3rd cycle after the input level changes; no backpressure (one pulse per level change).
module toggle_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_tgl,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_tgl;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_pulse = r_s2 ^ r_s3;

endmodule

// File: rtl/signal_lock_controller.sv
// Measures incoming line/field timing and runs the NO_SIGNAL/ACQUIRE/LOCKED/HOLD lock FSM; LOCK_STATS_EN adds loss_count.
// Latency: state moves on the sync'd field event, control outputs one cycle later; no backpressure (inputs free-running).
module signal_lock_controller
    import upscaler_pkg::*;
#(
    parameter int LINE_MIN    = DEF_LINE_MIN,
    parameter int LINE_MAX    = DEF_LINE_MAX,
    parameter int LINES_MIN   = DEF_LINES_MIN,
    parameter int LINES_MAX   = DEF_LINES_MAX,
    parameter int LOCK_FIELDS = DEF_LOCK_FIELDS,
    parameter int LOSS_FIELDS = DEF_LOSS_FIELDS,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        h_sync_tgl,
    input  logic        v_sync_tgl,
    output logic [1:0]  lock_state,
    output logic        locked,
    output logic        capture_en,
    output logic        live_sel,
    output logic [12:0] line_period,
    output logic [9:0]  field_lines,
    output logic [15:0] loss_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [12:0]     P_LMIN  = 13'(LINE_MIN);
    localparam logic [12:0]     P_LMAX  = 13'(LINE_MAX);
    localparam logic [9:0]      P_NMIN  = 10'(LINES_MIN);
    localparam logic [9:0]      P_NMAX  = 10'(LINES_MAX);
    localparam logic [7:0]      P_LOCK  = 8'(LOCK_FIELDS);
    localparam logic [7:0]      P_LOSS  = 8'(LOSS_FIELDS);
    localparam logic [TO_W-1:0] P_TO    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] P_TO_M1 = TO_W'(TIMEOUT - 1);

    logic              w_h;
    logic              w_v;
    logic              w_h_bad;
    logic              w_good;
    logic              w_timeout;
    logic [9:0]        w_close_lines;
    logic [12:0]       r_per_cnt;
    logic [9:0]        r_line_cnt;
    logic              r_bad;
    logic              r_first;
    logic [TO_W-1:0]   r_to_cnt;
    logic [7:0]        r_good_cnt;
    logic [7:0]        r_bad_cnt;
    lock_state_t       r_state;
    logic              r_locked;
    logic              r_capture;
    logic              r_live;
    logic [12:0]       r_line_period;
    logic [9:0]        r_field_lines;

    toggle_sync u_h_sync (.sys_clk(sys_clk), .sys_rst(sys_rst), .i_tgl(h_sync_tgl), .o_pulse(w_h));
    toggle_sync u_v_sync (.sys_clk(sys_clk), .sys_rst(sys_rst), .i_tgl(v_sync_tgl), .o_pulse(w_v));

    // A line coinciding with the field event still belongs to the field being closed.
    assign w_h_bad       = w_h && !r_first && ((r_per_cnt < P_LMIN) || (r_per_cnt > P_LMAX));
    assign w_close_lines = (w_h && (r_line_cnt != 10'h3FF)) ? r_line_cnt + 10'd1 : r_line_cnt;
    assign w_good        = !(r_bad || w_h_bad) && (w_close_lines >= P_NMIN) && (w_close_lines <= P_NMAX);
    assign w_timeout     = (r_to_cnt == P_TO_M1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_per_cnt     <= '0;
            r_line_period <= '0;
            r_line_cnt    <= '0;
            r_field_lines <= '0;
            r_bad         <= 1'b0;
            r_first       <= 1'b1;
            r_to_cnt      <= '0;
        end else begin
            if (w_h) begin
                r_per_cnt     <= 13'd1;
                r_line_period <= r_per_cnt;
            end else if (r_per_cnt != 13'h1FFF) begin
                r_per_cnt <= r_per_cnt + 13'd1;
            end
            if (w_v) begin
                r_line_cnt    <= '0;
                r_field_lines <= w_close_lines;
                r_bad         <= 1'b0;
                r_first       <= 1'b1;
                r_to_cnt      <= '0;
            end else begin
                if (w_h) begin
                    r_line_cnt <= w_close_lines;
                    r_first    <= 1'b0;
                end
                if (w_h_bad)
                    r_bad <= 1'b1;
                if (r_to_cnt != P_TO)
                    r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= NO_SIGNAL;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_locked   <= 1'b0;
            r_capture  <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_locked  <= (r_state == LOCKED) || (r_state == HOLD);
            r_capture <= (r_state == LOCKED);
            r_live    <= (r_state == LOCKED) || (r_state == HOLD);
            if (w_timeout) begin
                r_state    <= NO_SIGNAL;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
            end else if (w_v) begin
                case (r_state)
                    NO_SIGNAL: begin
                        r_state    <= ACQUIRE;
                        r_good_cnt <= '0;
                    end
                    ACQUIRE: begin
                        if (!w_good)
                            r_good_cnt <= '0;
                        else begin
                            r_good_cnt <= r_good_cnt + 8'd1;
                            if (r_good_cnt >= P_LOCK - 8'd1)
                                r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (!w_good) begin
                            r_state   <= HOLD;
                            r_bad_cnt <= 8'd1;
                        end
                    end
                    HOLD: begin
                        if (w_good) begin
                            r_state   <= LOCKED;
                            r_bad_cnt <= '0;
                        end else if (r_bad_cnt >= P_LOSS - 8'd1) begin
                            r_state    <= ACQUIRE;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 8'd1;
                        end
                    end
                    default: r_state <= NO_SIGNAL;
                endcase
            end
        end
    end

`ifdef LOCK_STATS_EN
    logic        w_exit;
    logic [15:0] r_loss_cnt;

    assign w_exit = ((r_state == LOCKED) || (r_state == HOLD)) &&
                    (w_timeout || ((r_state == HOLD) && w_v && !w_good && (r_bad_cnt >= P_LOSS - 8'd1)));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_loss_cnt <= '0;
        else if (w_exit && (r_loss_cnt != 16'hFFFF))
            r_loss_cnt <= r_loss_cnt + 16'd1;
    end

    assign loss_count = r_loss_cnt;
`else
    assign loss_count = '0;
`endif

    assign lock_state  = r_state;
    assign locked      = r_locked;
    assign capture_en  = r_capture;
    assign live_sel    = r_live;
    assign line_period = r_line_period;
    assign field_lines = r_field_lines;

endmodule

// File: tb/tb_signal_lock_controller.sv
// Directed bench for signal_lock_controller with shortened line period and timeout; field sizes are NTSC-like.
module tb_signal_lock_controller;
    import upscaler_pkg::*;

    localparam int PER     = 6;
    localparam int SETTLE  = 6;
    localparam int TO_CYC  = 3000;
`ifdef LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        h_sync_tgl;
    logic        v_sync_tgl;
    logic [1:0]  lock_state;
    logic        locked;
    logic        capture_en;
    logic        live_sel;
    logic [12:0] line_period;
    logic [9:0]  field_lines;
    logic [15:0] loss_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lines;
        int alt_idx;
        int alt_per;
        int st;
        int lk;
        int cap;
        int live;
        int lper;
        int loss;
    } vec_t;

    vec_t vecs[$];

    signal_lock_controller #(
        .LINE_MIN(5), .LINE_MAX(7), .LINES_MIN(240), .LINES_MAX(320),
        .LOCK_FIELDS(4), .LOSS_FIELDS(3), .TIMEOUT(TO_CYC)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .h_sync_tgl(h_sync_tgl), .v_sync_tgl(v_sync_tgl),
        .lock_state(lock_state), .locked(locked), .capture_en(capture_en), .live_sel(live_sel),
        .line_period(line_period), .field_lines(field_lines), .loss_count(loss_count)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int lines, input int alt_idx, input int alt_per, input int st,
                       input int lk, input int cap, input int live, input int lper, input int loss);
        vec_t v;
        v = '{lines: lines, alt_idx: alt_idx, alt_per: alt_per, st: st, lk: lk,
              cap: cap, live: live, lper: lper, loss: loss};
        vecs.push_back(v);
    endtask

    // Line i waits alt_per cycles when i == alt_idx; the closing line toggles v in the same cycle as h.
    task automatic drive_lines(input int n, input int alt_idx, input int alt_per, input bit close);
        for (int i = 1; i <= n; i++) begin
            repeat ((i == alt_idx) ? alt_per : PER) @(negedge sys_clk);
            h_sync_tgl = ~h_sync_tgl;
            if (close && (i == n))
                v_sync_tgl = ~v_sync_tgl;
        end
        if (close)
            repeat (SETTLE) @(negedge sys_clk);
    endtask

    task automatic check_ctrl(input string tag, input int st, input int lk, input int cap, input int live);
        check({tag, " state"}, 32'(lock_state), st);
        check({tag, " locked"}, 32'(locked), lk);
        check({tag, " capture_en"}, 32'(capture_en), cap);
        check({tag, " live_sel"}, 32'(live_sel), live);
    endtask

    initial begin
        logic h_at;
        logic v_at;
        int   exp_fl;

        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 0);
        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 0);
        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 0);
        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 0);
        add(262, 0, 0, LOCKED, 1, 1, 1, 6, 0);
        add(262, 100, 4, HOLD, 1, 0, 1, 6, 0);
        add(262, 0, 0, LOCKED, 1, 1, 1, 6, 0);
        add(200, 0, 0, HOLD, 1, 0, 1, 6, 0);
        add(200, 0, 0, HOLD, 1, 0, 1, 6, 0);
        add(200, 0, 0, ACQUIRE, 0, 0, 0, 6, 1);
        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 1);
        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 1);
        add(262, 0, 0, ACQUIRE, 0, 0, 0, 6, 1);
        add(240, 0, 0, LOCKED, 1, 1, 1, 6, 1);
        add(320, 0, 0, LOCKED, 1, 1, 1, 6, 1);
        add(321, 0, 0, HOLD, 1, 0, 1, 6, 1);
        add(262, 0, 0, LOCKED, 1, 1, 1, 6, 1);
        add(239, 0, 0, HOLD, 1, 0, 1, 6, 1);
        add(262, 0, 0, LOCKED, 1, 1, 1, 6, 1);
        add(262, 262, 7, LOCKED, 1, 1, 1, 7, 1);
        add(262, 262, 8, HOLD, 1, 0, 1, 8, 1);
        add(262, 0, 0, LOCKED, 1, 1, 1, 6, 1);
        add(262, 262, 5, LOCKED, 1, 1, 1, 5, 1);
        add(262, 262, 4, HOLD, 1, 0, 1, 4, 1);
        add(262, 0, 0, LOCKED, 1, 1, 1, 6, 1);
        add(262, 1, 30, LOCKED, 1, 1, 1, 6, 1);

        sys_rst    = 1'b1;
        h_sync_tgl = 1'b0;
        v_sync_tgl = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_ctrl("reset", NO_SIGNAL, 0, 0, 0);
        check("reset line_period", 32'(line_period), 0);
        check("reset field_lines", 32'(field_lines), 0);
        check("reset loss_count", 32'(loss_count), 0);

        foreach (vecs[k]) begin
            drive_lines(vecs[k].lines, vecs[k].alt_idx, vecs[k].alt_per, 1'b1);
            check_ctrl($sformatf("row%0d", k), vecs[k].st, vecs[k].lk, vecs[k].cap, vecs[k].live);
            check($sformatf("row%0d field_lines", k), 32'(field_lines), vecs[k].lines);
            check($sformatf("row%0d line_period", k), 32'(line_period), vecs[k].lper);
            check($sformatf("row%0d loss_count", k), 32'(loss_count), STATS ? vecs[k].loss : 0);
        end

        // Inputs frozen: still locked shortly before the timeout, NO_SIGNAL shortly after.
        repeat (TO_CYC - 20) @(negedge sys_clk);
        check_ctrl("pre-timeout", LOCKED, 1, 1, 1);
        repeat (30) @(negedge sys_clk);
        check_ctrl("timeout", NO_SIGNAL, 0, 0, 0);
        check("timeout loss_count", 32'(loss_count), STATS ? 2 : 0);

        for (int f = 1; f <= 5; f++) begin
            drive_lines(262, 0, 0, 1'b1);
            check_ctrl($sformatf("relock%0d", f), (f == 5) ? LOCKED : ACQUIRE,
                       (f == 5) ? 1 : 0, (f == 5) ? 1 : 0, (f == 5) ? 1 : 0);
        end

        // Reset in the middle of a locked field.
        drive_lines(100, 0, 0, 1'b0);
        h_at = h_sync_tgl;
        v_at = v_sync_tgl;
        sys_rst = 1'b1;
        #1;
        check_ctrl("midreset", NO_SIGNAL, 0, 0, 0);
        check("midreset line_period", 32'(line_period), 0);
        check("midreset field_lines", 32'(field_lines), 0);
        check("midreset loss_count", 32'(loss_count), 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        drive_lines(162, 0, 0, 1'b1);
        exp_fl = 162 + ((h_at && !v_at) ? 1 : 0);
        check_ctrl("postreset1", ACQUIRE, 0, 0, 0);
        check("postreset1 field_lines", 32'(field_lines), exp_fl);
        for (int f = 2; f <= 5; f++) begin
            drive_lines(262, 0, 0, 1'b1);
            check_ctrl($sformatf("postreset%0d", f), (f == 5) ? LOCKED : ACQUIRE,
                       (f == 5) ? 1 : 0, (f == 5) ? 1 : 0, (f == 5) ? 1 : 0);
        end
        check("postreset field_lines", 32'(field_lines), 262);
        check("postreset loss_count", 32'(loss_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
